gate_truth_checker: RTL and testbench

Self-checking exerciser for the team's primitive gate library (NOT, AND, OR, NAND, NOR, XOR, XNOR).
- Drives the shared two-bit stimulus (a, b) into a bank of gate instances through all four input combinations.
- Waits a configurable settle time, then samples the seven gate outputs and compares them against a golden model.
- Reports mismatch count, per-gate failure mask and pass/fail through a start/done handshake.
- Sits on the opposite side of the gates: it is the initiator whose stimulus they answer, used in bring-up benches and on-chip self-test.

---
 rtl/gate_chk_pkg.sv | 32 +++
 rtl/gate_ref_model.sv | 23 ++
 rtl/gate_truth_checker.sv | 136 +++++++++++++
 tb/tb_gate_truth_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the primitive gate exerciser: gate bit positions,
// checker FSM states and the vector count.
package gate_chk_pkg;

  localparam int NUM_GATES   = 7;
  localparam int NUM_VECTORS = 4;

  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Number of set bits in a gate response vector (0..7).
  function automatic logic [2:0] popcount_gates(input logic [NUM_GATES-1:0] v);
    logic [2:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_GATES; i++) sum = sum + {2'b00, v[i]};
    return sum;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the primitive gate bank: (a, b) -> expected
// outputs in the shared bit order.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] y
);

  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    y            = '0;
    y[GATE_NOT]  = ~a;
    y[GATE_AND]  = a & b;
    y[GATE_OR]   = a | b;
    y[GATE_NAND] = ~(a & b);
    y[GATE_NOR]  = ~(a | b);
    y[GATE_XOR]  = a ^ b;
    y[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Drives all four (a,b) vectors into a gate bank, checks responses against the
// golden model. Optional first-failure capture: define GATE_CHK_FIRST_FAIL_EN.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 stim_a,
  output logic                 stim_b,
  input  logic [NUM_GATES-1:0] resp_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [1:0]           first_fail_vec,
  output logic [NUM_GATES-1:0] first_fail_mask
);

  localparam int                SUM_W    = ERR_CNT_W + 4;
  localparam logic [SUM_W-1:0]  ERR_MAX  = {4'b0000, {ERR_CNT_W{1'b1}}};
  localparam logic [1:0]        LAST_IDX = 2'(NUM_VECTORS - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t               state, next_state;
  logic [1:0]           idx;
  logic [3:0]           settle_cnt;
  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mismatch;
  logic [SUM_W-1:0]     err_sum;
  logic                 accumulate;

  gate_ref_model u_ref (
    .a (stim_a),
    .b (stim_b),
    .y (expected)
  );

  assign mismatch   = resp_y ^ expected;
  assign accumulate = (state == ST_CHECK) && !abort;
  assign err_sum    = SUM_W'(err_cnt) + SUM_W'(popcount_gates(mismatch));

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_DRIVE;
      ST_DRIVE: begin
        if (abort)                  next_state = ST_IDLE;
        else if (SETTLE_CYCLES > 0) next_state = ST_SETTLE;
        else                        next_state = ST_CHECK;
      end
      ST_SETTLE: begin
        if (abort)                           next_state = ST_IDLE;
        else if (settle_cnt == SETTLE_LAST)  next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)                 next_state = ST_IDLE;
        else if (idx == LAST_IDX)  next_state = ST_DONE;
        else                       next_state = ST_DRIVE;
      end
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the current state, so they trail it by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      stim_a     <= 1'b0;
      stim_b     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_mask  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register here see pre-edge values.
      state <= next_state;
      busy  <= (state inside {ST_DRIVE, ST_SETTLE, ST_CHECK}) && !abort;
      done  <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            err_cnt   <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
          end
        end
        ST_DRIVE: begin
          stim_a     <= idx[1];
          stim_b     <= idx[0];
          settle_cnt <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        ST_CHECK: begin
          if (accumulate) begin
            fail_mask <= fail_mask | mismatch;
            err_cnt   <= (err_sum > ERR_MAX) ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
            if (idx != LAST_IDX) idx <= idx + 2'd1;
          end
        end
        ST_DONE:  pass <= (fail_mask == '0);
        default: ;
      endcase
    end
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  // A zero capture mask doubles as the "nothing captured yet" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else if ((state == ST_IDLE) && start) begin
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else if (accumulate && (mismatch != '0) && (first_fail_mask == '0)) begin
      first_fail_vec  <= {stim_a, stim_b};
      first_fail_mask <= mismatch;
    end
  end
`else
  assign first_fail_vec  = '0;
  assign first_fail_mask = '0;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench for gate_truth_checker: a faultable gate bank on one
// checker (defaults) and an all-inverted bank on a narrow, zero-settle checker.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0, abort = 1'b0;
  int   mode = 0;
  bit   sel = 1'b0;

  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [6:0] mask1, ffm1, resp1;
  logic [1:0] ffv1;
  logic       a2, b2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [6:0] mask2, ffm2, resp2;
  logic [1:0] ffv2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         err;
    logic [6:0] mask;
    logic [1:0] ffv;
    logic [6:0] ffm;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Bench-side gate bank, written independently of the RTL model.
  function automatic logic [6:0] bank(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
  endfunction

  function automatic logic [6:0] faulty(input logic [6:0] g, input int m);
    case (m)
      1:       return g & 7'b1111101;
      2:       return g | 7'b0000001;
      3:       return ~g;
      default: return g;
    endcase
  endfunction

  assign resp1 = faulty(bank(a1, b1), mode);
  assign resp2 = ~bank(a2, b2);

  gate_truth_checker u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .stim_a(a1), .stim_b(b1), .resp_y(resp1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .fail_mask(mask1),
    .first_fail_vec(ffv1), .first_fail_mask(ffm1)
  );

  gate_truth_checker #(.SETTLE_CYCLES(0), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .stim_a(a2), .stim_b(b2), .resp_y(resp2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2), .fail_mask(mask2),
    .first_fail_vec(ffv2), .first_fail_mask(ffm2)
  );

  logic       o_busy, o_done, o_pass;
  logic [7:0] o_err;
  logic [6:0] o_mask, o_ffm;
  logic [1:0] o_ffv;
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;
  assign o_pass = sel ? pass2 : pass1;
  assign o_err  = sel ? {6'b0, err2} : err1;
  assign o_mask = sel ? mask2 : mask1;
  assign o_ffv  = sel ? ffv2 : ffv1;
  assign o_ffm  = sel ? ffm2 : ffm1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int err, input logic [6:0] mask, input logic [1:0] ffv,
                          input logic [6:0] ffm, input int lat);
    exp_t e;
    e.err  = err;
    e.mask = mask;
`ifdef GATE_CHK_FIRST_FAIL_EN
    e.ffv  = ffv;
    e.ffm  = ffm;
`else
    e.ffv  = 2'b00;
    e.ffm  = 7'b0;
`endif
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // One full run: start in the next cycle, expectations queued, compared at done.
  task automatic run(input string tag, input bit which, input int fmode);
    exp_t e;
    int   n;
    sel  = which;
    mode = fmode;
    @(negedge clk);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    n = 0;
    while (!o_done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check({tag, " busy_rise"}, o_busy, 1'b1);
        check({tag, " pass_cleared"}, o_pass, 1'b0);
      end
    end
    e = sb.pop_front();
    check({tag, " latency"}, n, e.lat);
    check({tag, " busy_fall"}, o_busy, 1'b0);
    check({tag, " err_cnt"}, o_err, e.err);
    check({tag, " fail_mask"}, o_mask, e.mask);
    check({tag, " pass"}, o_pass, (e.mask == 7'b0));
    check({tag, " first_fail_vec"}, o_ffv, e.ffv);
    check({tag, " first_fail_mask"}, o_ffm, e.ffm);
  endtask

  initial begin
    int dones, busys;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst busy", busy1, 1'b0);
    check("rst done", done1, 1'b0);
    check("rst stim", {a1, b1}, 2'b00);
    check("rst outputs", {pass1, err1, mask1, ffv1, ffm1}, '0);
    rst_n = 1'b1;

    // Back-to-back runs on the default checker
    push_exp(1, 7'b0000010, 2'b11, 7'b0000010, 17);
    run("and_sa0", 1'b0, 1);
    push_exp(2, 7'b0000001, 2'b10, 7'b0000001, 17);
    run("not_sa1", 1'b0, 2);
    push_exp(0, 7'b0, 2'b00, 7'b0, 17);
    run("good", 1'b0, 0);
    repeat (3) @(posedge clk); #1;
    check("done single cycle", done1, 1'b0);
    check("pass held", pass1, 1'b1);

    // Narrow counter saturation, zero settle
    push_exp(3, 7'b1111111, 2'b00, 7'b1111111, 9);
    run("invert_sat", 1'b1, 0);

    // Abort during SETTLE of vector 01, with an ignored start mid-run
    sel = 1'b0; mode = 3;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort vec01 stim", {a1, b1}, 2'b01);
    check("abort busy before", busy1, 1'b1);
    check("abort partial err", err1, 8'd7);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort busy fall", busy1, 1'b0);
    check("abort err held", err1, 8'd7);
    check("abort mask held", mask1, 7'h7F);
    check("abort pass", pass1, 1'b0);
    dones = 0; busys = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done1) dones++;
      if (busy1) busys++;
    end
    check("abort no done", dones, 0);
    check("abort stays idle", busys, 0);

    // Asynchronous reset during CHECK of vector 01
    mode = 3;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre-rst busy", busy1, 1'b1);
    check("pre-rst stim", {a1, b1}, 2'b01);
    check("pre-rst err", err1, 8'd7);
    #2 rst_n = 1'b0;
    #1;
    check("midrun rst busy", busy1, 1'b0);
    check("midrun rst stim", {a1, b1}, 2'b00);
    check("midrun rst outputs", {done1, pass1, err1, mask1, ffv1, ffm1}, '0);
    @(negedge clk); rst_n = 1'b1;
    push_exp(0, 7'b0, 2'b00, 7'b0, 17);
    run("after_rst", 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
